bias_act_requant: RTL and testbench

// - Post-accumulation stage that sits directly downstream of bias_store, one output group (8 channels) per beat.
// - Fetches the group's biases from bias_store on demand and caches them.
// - Adds the biases to the conv accumulators, applies leaky-ReLU (slope 13/128), then requantizes (scale, round, shift).
// - Saturates to int8 and streams results to the output writer with valid/ready.

---
 rtl/bias_act_pkg.sv | 27 ++
 rtl/requant_lane.sv | 79 +++++++
 rtl/bias_act_requant.sv | 166 ++++++++++++++++
 tb/tb_bias_act_requant.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_act_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bias_act_pkg
// Brief    : Shared types and constants for the bias/activation/requant stage.
// Revision : 1.0 - initial release
// ============================================================================
package bias_act_pkg;

    // Bias-cache controller states
    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        READY = 3'd4
    } bias_fsm_t;

    // Leaky-ReLU negative slope is LEAKY_MUL / 2**LEAKY_SHIFT (13/128)
    localparam int LEAKY_MUL   = 13;
    localparam int LEAKY_SHIFT = 7;

    // int8 saturation bounds
    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

endpackage
`default_nettype wire

// File: rtl/requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : One lane of stages 2-3: leaky-ReLU, scale multiply, rounding
//            right shift and int8 saturation. Both stages advance on i_adv.
// Revision : 1.0 - initial release
// ============================================================================
module requant_lane
    import bias_act_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_adv,
    input  logic signed [ACC_W:0]     i_sum,
    input  logic        [SCALE_W-1:0] i_scale,
    input  logic        [4:0]         i_shift,
    input  logic                      i_leaky_en,
    output logic signed [OUT_W-1:0]   o_out
);

    localparam int SUM_W  = ACC_W + 1;
    localparam int MUL_W  = SUM_W + 4;            // room for x13
    localparam int PROD_W = SUM_W + SCALE_W + 1;  // signed act x unsigned scale
    localparam int RND_W  = PROD_W + 1;           // headroom for rounding add

    logic signed [MUL_W-1:0]  w_mul;
    logic signed [MUL_W-1:0]  w_leaky;
    logic signed [SUM_W-1:0]  w_act;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [RND_W-1:0]  w_rnd;
    logic signed [RND_W-1:0]  w_rsum;
    logic signed [RND_W-1:0]  w_shr;
    logic signed [OUT_W-1:0]  w_sat;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [OUT_W-1:0]  r_out;

    // Stage 2 datapath: floor-scaled negative slope, then scale multiply
    always_comb begin
        w_mul   = MUL_W'(i_sum) * MUL_W'(LEAKY_MUL);
        w_leaky = w_mul >>> LEAKY_SHIFT;
        w_act   = (i_leaky_en && i_sum[SUM_W-1]) ? w_leaky[SUM_W-1:0] : i_sum;
        w_prod  = PROD_W'(w_act) * PROD_W'($signed({1'b0, i_scale}));
    end

    // Stage 3 datapath: round-half-up shift (no rounding term at shift 0), clamp
    always_comb begin
        w_rnd = '0;
        if (i_shift != 5'd0) begin
            w_rnd = RND_W'(1) << (i_shift - 5'd1);
        end
        w_rsum = RND_W'(r_prod) + w_rnd;
        w_shr  = w_rsum >>> i_shift;
        w_sat  = w_shr[OUT_W-1:0];
        if (w_shr > RND_W'(INT8_MAX)) begin
            w_sat = OUT_W'(INT8_MAX);
        end else if (w_shr < RND_W'(INT8_MIN)) begin
            w_sat = OUT_W'(INT8_MIN);
        end
    end

    // Stage 2/3 registers, frozen together while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_out  <= '0;
        end else if (i_adv) begin
            r_prod <= w_prod;
            r_out  <= w_sat;
        end
    end

    assign o_out = r_out;

endmodule
`default_nettype wire

// File: rtl/bias_act_requant.sv
`default_nettype none
// ============================================================================
// Module   : bias_act_requant
// Brief    : Bias add + leaky-ReLU + requantize to int8, one 8-channel group
//            per beat. Holds the bias-cache FSM, stage 1 and stall control;
//            stages 2-3 live in requant_lane.
// Revision : 1.0 - initial release
// ============================================================================
module bias_act_requant
    import bias_act_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int ACC_W   = 32,
    parameter int GROUP_W = 7,
    parameter int SCALE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SCALE_W-1:0]         cfg_scale,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_leaky_en,
    input  logic                       bias_invalidate,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [GROUP_W-1:0]         acc_group,
    input  logic [NUM_CH*ACC_W-1:0]    acc_data,
    output logic                       rd_en,
    output logic [GROUP_W-1:0]         rd_group,
    input  logic signed [ACC_W-1:0]    bias_in [0:NUM_CH-1],
    input  logic                       rd_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_CH*OUT_W-1:0]    out_data
);

    bias_fsm_t                r_state;
    logic                     r_cache_valid;
    logic [GROUP_W-1:0]       r_cached_group;
    logic signed [ACC_W-1:0]  r_cache [NUM_CH];
    logic                     r_rd_en;
    logic [GROUP_W-1:0]       r_rd_group;
    logic                     r_v1;
    logic                     r_v2;
    logic                     r_v3;
    logic signed [ACC_W:0]    r_s1_sum [NUM_CH];
    logic                     w_adv;
    logic                     w_hit;
    logic                     w_accept;

    assign w_adv     = !r_v3 || out_ready;
    assign w_hit     = (r_state == READY) && r_cache_valid && (acc_group == r_cached_group);
    assign acc_ready = w_hit && w_adv;
    assign w_accept  = acc_valid && acc_ready;

    // Bias-cache controller: fetch on miss, drop returned data after invalidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= EMPTY;
            r_cache_valid  <= 1'b0;
            r_cached_group <= '0;
            r_rd_en        <= 1'b0;
            r_rd_group     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cache[i] <= '0;
            end
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                EMPTY: begin
                    if (!bias_invalidate && acc_valid) begin
                        r_state    <= FETCH;
                        r_rd_en    <= 1'b1;
                        r_rd_group <= acc_group;
                    end
                end
                FETCH: begin
                    r_state <= bias_invalidate ? DRAIN : WAIT;
                end
                WAIT: begin
                    // Invalidate coinciding with the return discards it outright
                    if (bias_invalidate) begin
                        r_state <= rd_valid ? EMPTY : DRAIN;
                    end else if (rd_valid) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            r_cache[i] <= bias_in[i];
                        end
                        r_cached_group <= r_rd_group;
                        r_cache_valid  <= 1'b1;
                        r_state        <= READY;
                    end
                end
                DRAIN: begin
                    if (rd_valid) begin
                        r_state <= EMPTY;
                    end
                end
                READY: begin
                    if (bias_invalidate) begin
                        r_state       <= EMPTY;
                        r_cache_valid <= 1'b0;
                    end else if (acc_valid && (acc_group != r_cached_group)) begin
                        r_state       <= FETCH;
                        r_cache_valid <= 1'b0;
                        r_rd_en       <= 1'b1;
                        r_rd_group    <= acc_group;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    // Stage 1 and valid chain: bias added at accept so later refills are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_s1_sum[i] <= '0;
            end
        end else if (w_adv) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (w_accept) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_s1_sum[i] <= (ACC_W+1)'($signed(acc_data[i*ACC_W +: ACC_W]))
                                 + (ACC_W+1)'(r_cache[i]);
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic signed [OUT_W-1:0] w_lane_out;

            requant_lane #(
                .ACC_W   (ACC_W),
                .SCALE_W (SCALE_W),
                .OUT_W   (OUT_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_adv      (w_adv),
                .i_sum      (r_s1_sum[gi]),
                .i_scale    (cfg_scale),
                .i_shift    (cfg_shift),
                .i_leaky_en (cfg_leaky_en),
                .o_out      (w_lane_out)
            );

            assign out_data[gi*OUT_W +: OUT_W] = w_lane_out;
        end
    endgenerate

    assign rd_en     = r_rd_en;
    assign rd_group  = r_rd_group;
    assign out_valid = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_bias_act_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_bias_act_requant
// Brief    : Directed bench with bias_store model and output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bias_act_requant;

    logic               clk;
    logic               rst_n;
    logic [15:0]        cfg_scale;
    logic [4:0]         cfg_shift;
    logic               cfg_leaky_en;
    logic               bias_invalidate;
    logic               acc_valid;
    logic               acc_ready;
    logic [6:0]         acc_group;
    logic [255:0]       acc_data;
    logic               rd_en;
    logic [6:0]         rd_group;
    logic signed [31:0] bias_in [0:7];
    logic               rd_valid;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    int          last_acc_cyc = 0;
    logic [6:0]  rd_groups [$];
    logic [63:0] exp_q [$];

    bias_act_requant dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_scale       (cfg_scale),
        .cfg_shift       (cfg_shift),
        .cfg_leaky_en    (cfg_leaky_en),
        .bias_invalidate (bias_invalidate),
        .acc_valid       (acc_valid),
        .acc_ready       (acc_ready),
        .acc_group       (acc_group),
        .acc_data        (acc_data),
        .rd_en           (rd_en),
        .rd_group        (rd_group),
        .bias_in         (bias_in),
        .rd_valid        (rd_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bias_store model: bias of channel n = n + 1, returned one cycle after rd_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                for (int i = 0; i < 8; i++) bias_in[i] <= 32'(int'(rd_group) * 8 + i + 1);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read-request log
    always @(negedge clk) begin
        if (rst_n && rd_en) begin
            rd_cnt++;
            rd_groups.push_back(rd_group);
        end
    end

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 64'd1);
            else                   check("out_data", out_data, exp_q.pop_front());
        end
    end

    function automatic logic [7:0] model_lane(longint acc, longint bias, bit leaky,
                                              longint scale, int shift);
        longint s, a, p, r;
        s = acc + bias;
        a = (leaky && s < 0) ? ((s * 13) >>> 7) : s;
        p = a * scale;
        r = (shift == 0) ? p : ((p + (longint'(1) <<< (shift - 1))) >>> shift);
        if (r > 127) r = 127;
        else if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [63:0] model_beat(int g, logic [255:0] d);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = model_lane(longint'($signed(d[i*32 +: 32])),
                                       longint'(g * 8 + i + 1), cfg_leaky_en,
                                       longint'(cfg_scale), int'(cfg_shift));
        end
        return res;
    endfunction

    function automatic logic [255:0] mk(int v0, int rest);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(rest);
        d[31:0] = 32'(v0);
        return d;
    endfunction

    function automatic logic [255:0] rnd_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(int'($urandom_range(0, 600)) - 300);
        return d;
    endfunction

    // Present a beat, wait (bounded) for acceptance, leave acc_valid high
    task automatic send(input logic [6:0] g, input logic [255:0] d);
        bit ok;
        ok = 1'b0;
        acc_valid = 1'b1;
        acc_group = g;
        acc_data  = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (acc_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(model_beat(int'(g), d));
            last_acc_cyc = cyc;
        end else begin
            check("accept_timeout", 64'(acc_ready), 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c_prev;
        logic [63:0] held;

        rst_n = 1'b0;
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_leaky_en = 1'b1;
        bias_invalidate = 1'b0;
        acc_valid = 1'b0;
        acc_group = '0;
        acc_data = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bias_in[i] = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_rd_en",     64'(rd_en),     64'd0);
        check("rst_rd_group",  64'(rd_group),  64'd0);
        check("rst_acc_ready", 64'(acc_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: cold fetch, group 2, all lanes 100
        r0 = rd_cnt;
        send(7'd2, mk(100, 100));
        acc_valid = 1'b0;
        @(negedge clk); check("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk); check("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk); check("lat_c3", 64'(out_valid), 64'd1);
        check("cold_lane0", 64'(out_data[7:0]),   64'd117);
        check("cold_lane7", 64'(out_data[63:56]), 64'd124);
        drain();
        check("cold_rd_cnt", 64'(rd_cnt - r0), 64'd1);
        check("cold_rd_grp", 64'(rd_groups[r0]), 64'd2);

        // 2: leaky / saturation
        send(7'd2, mk(-1017, 0));
        acc_valid = 1'b0;
        drain();
        cfg_leaky_en = 1'b0;
        send(7'd2, mk(-1017, 0));
        send(7'd2, mk(200, -5000));
        acc_valid = 1'b0;
        drain();
        cfg_leaky_en = 1'b1;

        // 3: requant with scale 3 / shift 3, group 0
        cfg_scale = 16'd3;
        cfg_shift = 5'd3;
        send(7'd0, mk(283, -77));
        acc_valid = 1'b0;
        drain();
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;

        // 4: group switching 0,0,0,1,1 from an invalidated cache
        bias_invalidate = 1'b1;
        @(posedge clk);
        #1 bias_invalidate = 1'b0;
        r0 = rd_cnt;
        send(7'd0, rnd_data());
        c_prev = last_acc_cyc;
        send(7'd0, rnd_data());
        check("same_grp_gap", 64'(last_acc_cyc - c_prev), 64'd1);
        send(7'd0, rnd_data());
        c_prev = last_acc_cyc;
        send(7'd1, rnd_data());
        check("switch_gap", 64'(last_acc_cyc - c_prev), 64'd4);
        c_prev = last_acc_cyc;
        send(7'd1, rnd_data());
        check("post_switch_gap", 64'(last_acc_cyc - c_prev), 64'd1);
        acc_valid = 1'b0;
        drain();
        check("switch_rd_cnt", 64'(rd_cnt - r0), 64'd2);
        check("switch_rd_g0", 64'(rd_groups[r0]),     64'd0);
        check("switch_rd_g1", 64'(rd_groups[r0 + 1]), 64'd1);

        // 5: 16 back-to-back beats with a 5-cycle output stall
        fork
            begin
                for (int k = 0; k < 16; k++) send(7'd1, rnd_data());
                acc_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_no_ready", 64'(acc_ready), 64'd0);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_hold", out_data, held);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // 6a: invalidate while the fetch is in WAIT
        r0 = rd_cnt;
        fork
            send(7'd3, rnd_data());
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (rd_en) break;
                end
                @(posedge clk);
                #1 bias_invalidate = 1'b1;
                @(posedge clk);
                #1 bias_invalidate = 1'b0;
            end
        join
        acc_valid = 1'b0;
        drain();
        check("inval_rd_cnt", 64'(rd_cnt - r0), 64'd2);

        // 6b: asynchronous reset mid-stream
        for (int k = 0; k < 4; k++) send(7'd3, rnd_data());
        rst_n = 1'b0;
        acc_valid = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data",  out_data,       64'd0);
        check("mid_rst_acc_ready", 64'(acc_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = rd_cnt;
        send(7'd3, rnd_data());
        acc_valid = 1'b0;
        drain();
        check("rst_refetch_cnt", 64'(rd_cnt - r0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
